// File: rtl/matvec3_pkg.sv
// Shared widths, element types and FSM encoding for the 3x3 matrix-vector multiplier.
package matvec3_pkg;
  localparam int N     = 3;
  localparam int IN_W  = 14;
  localparam int OUT_W = 28;

  typedef logic signed [IN_W-1:0]  elem_t;
  typedef logic signed [OUT_W-1:0] acc_t;

  typedef enum logic [2:0] {
    LOAD_START,
    LOAD_W,
    LOAD_X,
    COMPUTE,
    OUTPUT
  } state_t;
endpackage

// File: rtl/matvec3_mac.sv
// Signed 14x14 multiply feeding a 28-bit wrapping accumulator.
// sum is the running total including this cycle's product.
module matvec3_mac
  import matvec3_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    enable,
  input  logic signed [IN_W-1:0]  a,
  input  logic signed [IN_W-1:0]  b,
  output logic signed [OUT_W-1:0] sum
);
  acc_t acc_reg;
  acc_t prod;

  // Both operands widened first so the full 28-bit product is kept.
  assign prod = acc_t'(a) * acc_t'(b);
  assign sum  = (clear ? acc_t'(0) : acc_reg) + prod;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_reg <= '0;
    end else if (enable) begin
      acc_reg <= sum;
    end
  end
endmodule

// File: rtl/matvec3_part2.sv
// Streaming 3x3 signed matrix-vector multiplier y = W*x with matrix reuse.
// One row is accumulated per COMPUTE pass and handed out before the next row.
module matvec3_part2
  import matvec3_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             input_valid,
  output logic             input_ready,
  input  logic [IN_W-1:0]  input_data,
  input  logic             new_matrix,
  output logic             output_valid,
  input  logic             output_ready,
  output logic [OUT_W-1:0] output_data
);
  state_t     state_reg;
  logic       input_ready_reg;
  logic       output_valid_reg;
  acc_t       output_data_reg;
  logic [3:0] widx_reg;
  logic [1:0] xidx_reg;
  logic [1:0] row_reg;
  logic [1:0] col_reg;

  elem_t w_reg [0:N*N-1];
  elem_t x_reg [0:N-1];

  logic         in_fire;
  logic         w_we;
  logic         x_we;
  logic [3:0]   w_waddr;
  logic [1:0]   x_waddr;
  logic [3:0]   w_raddr;
  logic [N*N-1:0] w_sel;
  logic [N-1:0]   x_sel;
  acc_t         mac_sum;

  assign in_fire = input_valid && input_ready_reg;
  assign w_we    = in_fire && ((state_reg == LOAD_START && new_matrix) || state_reg == LOAD_W);
  assign x_we    = in_fire && ((state_reg == LOAD_START && !new_matrix) || state_reg == LOAD_X);
  assign w_waddr = (state_reg == LOAD_START) ? 4'd0 : widx_reg;
  assign x_waddr = (state_reg == LOAD_START) ? 2'd0 : xidx_reg;
  assign w_raddr = {1'b0, row_reg, 1'b0} + {2'b00, row_reg} + {2'b00, col_reg};

  genvar gi;
  generate
    for (gi = 0; gi < N*N; gi++) begin : g_w_sel
      assign w_sel[gi] = w_we && (w_waddr == 4'(gi));
    end
    for (gi = 0; gi < N; gi++) begin : g_x_sel
      assign x_sel[gi] = x_we && (x_waddr == 2'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N*N; i++) w_reg[i] <= '0;
      for (int i = 0; i < N; i++)   x_reg[i] <= '0;
    end else begin
      for (int i = 0; i < N*N; i++) if (w_sel[i]) w_reg[i] <= input_data;
      for (int i = 0; i < N; i++)   if (x_sel[i]) x_reg[i] <= input_data;
    end
  end

  matvec3_mac u_mac (
    .clk    (clk),
    .reset  (reset),
    .clear  (col_reg == 2'd0),
    .enable (state_reg == COMPUTE),
    .a      (w_reg[w_raddr]),
    .b      (x_reg[col_reg]),
    .sum    (mac_sum)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg        <= LOAD_START;
      input_ready_reg  <= 1'b0;
      output_valid_reg <= 1'b0;
      output_data_reg  <= '0;
      widx_reg         <= '0;
      xidx_reg         <= '0;
      row_reg          <= '0;
      col_reg          <= '0;
    end else begin
      case (state_reg)
        LOAD_START: begin
          input_ready_reg <= 1'b1;
          if (in_fire) begin
            if (new_matrix) begin
              widx_reg  <= 4'd1;
              state_reg <= LOAD_W;
            end else begin
              xidx_reg  <= 2'd1;
              state_reg <= LOAD_X;
            end
          end
        end
        LOAD_W: begin
          if (in_fire) begin
            if (widx_reg == 4'd8) begin
              xidx_reg  <= 2'd0;
              state_reg <= LOAD_X;
            end else begin
              widx_reg <= widx_reg + 4'd1;
            end
          end
        end
        LOAD_X: begin
          if (in_fire) begin
            if (xidx_reg == 2'd2) begin
              input_ready_reg <= 1'b0;
              row_reg         <= 2'd0;
              col_reg         <= 2'd0;
              state_reg       <= COMPUTE;
            end else begin
              xidx_reg <= xidx_reg + 2'd1;
            end
          end
        end
        COMPUTE: begin
          if (col_reg == 2'd2) begin
            output_data_reg  <= mac_sum;
            output_valid_reg <= 1'b1;
            col_reg          <= 2'd0;
            state_reg        <= OUTPUT;
          end else begin
            col_reg <= col_reg + 2'd1;
          end
        end
        OUTPUT: begin
          if (output_ready) begin
            output_valid_reg <= 1'b0;
            if (row_reg == 2'd2) begin
              input_ready_reg <= 1'b1;
              state_reg       <= LOAD_START;
            end else begin
              row_reg   <= row_reg + 2'd1;
              state_reg <= COMPUTE;
            end
          end
        end
        default: state_reg <= LOAD_START;
      endcase
    end
  end

  assign input_ready  = input_ready_reg;
  assign output_valid = output_valid_reg;
  assign output_data  = output_data_reg;
endmodule

// File: tb/tb_matvec3_part2.sv
// Directed-vector bench for matvec3_part2: table of transactions plus reset,
// latency, backpressure and idle sequences.
module tb_matvec3_part2;
  logic        clk = 1'b0;
  logic        reset;
  logic        input_valid;
  logic        input_ready;
  logic [13:0] input_data;
  logic        new_matrix;
  logic        output_valid;
  logic        output_ready;
  logic [27:0] output_data;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit nm;
    int w [9];
    int x [3];
    int y [3];
    bit gaps;
    bit lat;
  } vec_t;

  vec_t vecs [7];

  matvec3_part2 dut (
    .clk          (clk),
    .reset        (reset),
    .input_valid  (input_valid),
    .input_ready  (input_ready),
    .input_data   (input_data),
    .new_matrix   (new_matrix),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [27:0] act, input logic [27:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%h), required %0d (0x%h)", name, $signed(act), act, $signed(exp), exp);
    end else begin
      $display("ok   %s: %0d", name, $signed(act));
    end
  endtask

  task automatic send_word(input int d, input logic nm, input bit gaps);
    int guard;
    int idle;
    if (gaps) begin
      idle = $urandom_range(0, 3);
      repeat (idle) begin
        input_valid = 1'b0;
        input_data  = 'x;
        new_matrix  = 1'bx;
        @(posedge clk); #1;
      end
    end
    input_valid = 1'b1;
    input_data  = 14'(d);
    new_matrix  = nm;
    guard = 0;
    while (!input_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 200) begin
      n_cmp++;
      n_bad++;
      $display("FAIL input_ready_wait: got input_ready=0 for 200 cycles, required 1");
    end
    @(posedge clk); #1;
    input_valid = 1'b0;
    input_data  = 'x;
    new_matrix  = 1'bx;
  endtask

  task automatic send_vec_words(input int i);
    if (vecs[i].nm) begin
      for (int k = 0; k < 9; k++) send_word(vecs[i].w[k], (k == 0) ? 1'b1 : 1'bx, vecs[i].gaps);
      for (int k = 0; k < 3; k++) send_word(vecs[i].x[k], 1'bx, vecs[i].gaps);
    end else begin
      for (int k = 0; k < 3; k++) send_word(vecs[i].x[k], (k == 0) ? 1'b0 : 1'bx, vecs[i].gaps);
    end
  endtask

  task automatic recv(input int exp, input bit gaps, input bit chk_lat, input string tag);
    int lat;
    int guard;
    bit done;
    logic [27:0] held;
    lat = 0;
    guard = 0;
    done = 1'b0;
    output_ready = 1'b0;
    while (!output_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!output_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_valid_wait: got output_valid=0 for 100 cycles, required 1", tag);
      return;
    end
    if (chk_lat) check({tag, "_latency"}, 28'(lat), 28'd3);
    held = output_data;
    while (!done) begin
      if (gaps && guard < 20 && $urandom_range(0, 1) == 0) begin
        output_ready = 1'b0;
        @(posedge clk); #1;
        guard++;
        check({tag, "_hold_valid"}, {27'b0, output_valid}, 28'd1);
        check({tag, "_hold_data"}, output_data, held);
      end else begin
        check(tag, output_data, 28'(exp));
        output_ready = 1'b1;
        @(posedge clk); #1;
        output_ready = 1'b0;
        done = 1'b1;
      end
    end
  endtask

  task automatic run_vec(input int i);
    send_vec_words(i);
    for (int r = 0; r < 3; r++)
      recv(vecs[i].y[r], vecs[i].gaps, vecs[i].lat, $sformatf("v%0d_y%0d", i, r));
  endtask

  initial begin
    int cnt_v;
    int cnt_r;
    int guard;

    vecs[0].nm = 1'b1; vecs[0].w = '{10, -20, 30, 50, -60, 70, 80, 100, -110};
    vecs[0].x = '{40, 30, -20};  vecs[0].y = '{-800, -1200, 8400};
    vecs[0].gaps = 1'b0; vecs[0].lat = 1'b1;

    vecs[1].nm = 1'b0; vecs[1].w = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[1].x = '{50, -60, -70}; vecs[1].y = '{-400, 1200, 5700};
    vecs[1].gaps = 1'b0; vecs[1].lat = 1'b1;

    vecs[2] = vecs[0]; vecs[2].gaps = 1'b1; vecs[2].lat = 1'b0;
    vecs[3] = vecs[1]; vecs[3].gaps = 1'b1; vecs[3].lat = 1'b0;

    vecs[4].nm = 1'b1;
    vecs[4].w = '{-8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192, -8192};
    vecs[4].x = '{-8192, -8192, -8192};
    vecs[4].y = '{-67108864, -67108864, -67108864};
    vecs[4].gaps = 1'b0; vecs[4].lat = 1'b1;

    vecs[5].nm = 1'b0; vecs[5].w = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[5].x = '{1, 2, 3}; vecs[5].y = '{-49152, -49152, -49152};
    vecs[5].gaps = 1'b1; vecs[5].lat = 1'b0;

    vecs[6].nm = 1'b0; vecs[6].w = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[6].x = '{1, 2, 3}; vecs[6].y = '{0, 0, 0};
    vecs[6].gaps = 1'b0; vecs[6].lat = 1'b1;

    reset        = 1'b0;
    input_valid  = 1'b0;
    input_data   = 'x;
    new_matrix   = 1'bx;
    output_ready = 1'b0;
    #2;
    check("reset_output_valid", {27'b0, output_valid}, 28'd0);
    check("reset_output_data", output_data, 28'd0);
    check("reset_input_ready", {27'b0, input_ready}, 28'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i);

    cnt_v = 0;
    cnt_r = 0;
    repeat (100) begin
      @(posedge clk); #1;
      if (output_valid) cnt_v++;
      if (!input_ready) cnt_r++;
    end
    check("idle_valid_high_cycles", 28'(cnt_v), 28'd0);
    check("idle_ready_low_cycles", 28'(cnt_r), 28'd0);

    // Reset while a result is waiting: W must come back cleared.
    send_vec_words(0);
    guard = 0;
    while (!output_valid && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("pre_reset_output_valid", {27'b0, output_valid}, 28'd1);
    reset = 1'b0;
    #1;
    check("midout_reset_valid", {27'b0, output_valid}, 28'd0);
    check("midout_reset_data", output_data, 28'd0);
    check("midout_reset_ready", {27'b0, input_ready}, 28'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    run_vec(6);

    // Reset partway through a matrix load, then a clean full load.
    for (int k = 0; k < 5; k++) send_word(vecs[0].w[k], (k == 0) ? 1'b1 : 1'bx, 1'b0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midload_reset_valid", {27'b0, output_valid}, 28'd0);
    reset = 1'b1;
    run_vec(0);
    run_vec(1);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/matvec3_part2.md
Name: matvec3_part2

Overview:
- Streaming 3x3 signed matrix–vector multiplier with matrix reuse. Computes y = W·x.
- A transaction either loads a new matrix followed by a vector, or loads only a vector and reuses the stored matrix.
- Inputs and outputs both use valid/ready handshakes.
- Sits between an upstream word source and a downstream result consumer in the accelerator datapath.

Parameters:
- None. Widths are fixed: N=3, input 14-bit signed, output 28-bit signed.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- input_valid  input  1  upstream word valid.
- input_ready  output  1  DUT can accept a word this cycle.
- input_data  input  14  signed matrix or vector element.
- new_matrix  input  1  sampled only on the first word of a transaction: 1 = matrix follows, 0 = vector only.
- output_valid  output  1  output_data holds a valid result.
- output_ready  input  1  downstream accepts output this cycle.
- output_data  output  28  signed result element y[i].

Behaviour:
- Reset (reset=0, asynchronous):
  - State returns to LOAD_START.
  - output_valid=0, output_data=0, input_ready=0 while reset is asserted.
  - Matrix store W cleared to 0, vector store X cleared to 0, all counters cleared.
  - Reset mid-operation aborts the transaction; nothing partial is output.
- Input handshake:
  - A word transfers on a rising edge where input_valid && input_ready.
  - input_data and new_matrix are don't-care (may be X) when input_valid=0.
- Word order:
  - new_matrix=1 transaction: 12 words: W row-major (w00,w01,w02,w10,…,w22), then x0,x1,x2.
  - new_matrix=0 transaction: 3 words x0,x1,x2. Stored W is unchanged.
  - new_matrix=0 as the first transaction after reset uses W=0, so outputs are 0.
- States:
  - LOAD_START: input_ready=1. On transfer, write word to w00 and go to LOAD_W if new_matrix=1; otherwise write it to x0 and go to LOAD_X.
  - LOAD_W: input_ready=1. Write words to w01..w22. After w22 transfers, go to LOAD_X.
  - LOAD_X: input_ready=1. Write words to the remaining X entries. After x2 transfers, go to COMPUTE with row r=0.
  - COMPUTE: input_ready=0. 3 cycles. acc = Σ_k w[r][k]·x[k], sign-extended 28-bit multiply and accumulate. On the last cycle, register acc into output_data, set output_valid=1, go to OUTPUT.
  - OUTPUT: input_ready=0. Hold output_data and output_valid stable while output_ready=0. On transfer (output_valid && output_ready): if r<2, set r=r+1, clear output_valid, go to COMPUTE; if r=2, clear output_valid and go to LOAD_START, with input_ready=1 the next cycle.
- Arithmetic: each 14x14 product is exactly 28-bit signed. The 3-term sum wraps modulo 2^28 (two's complement); no saturation.
- Latency:
  - First output_valid rises 3 cycles after the x2 transfer edge.
  - Each subsequent result is valid 3 cycles after the previous output transfer.
- output_valid is never asserted outside OUTPUT. It stays 0 indefinitely once inputs stop.
- No input is accepted while results are pending. Back-to-back transactions are fully serialized.

Decomposition:
- Package matvec3_pkg:
  - localparams N=3, IN_W=14, OUT_W=28.
  - typedef logic signed [IN_W-1:0] elem_t.
  - typedef logic signed [OUT_W-1:0] acc_t.
  - state enum {LOAD_START, LOAD_W, LOAD_X, COMPUTE, OUTPUT}.
- One sub-module, matvec3_mac:
  - Signed 14x14 multiply plus 28-bit accumulator.
  - clear and enable inputs.
  - Asynchronous active-low reset.
- Top level holds the FSM, the W/X register arrays and the counters.

Test Plan:
- Load W = [10,-20,30; 50,-60,70; 80,100,-110] with new_matrix=1, then x=(40,30,-20) -> outputs -800, -1200, 8400 in order.
- Then new_matrix=0 with x=(50,-60,-70) -> outputs -400, 1200, 5700, reusing W.
- Randomized input_valid/output_ready gaps, with X on input_data when invalid -> same results. No word is lost or duplicated. output_data is held stable under backpressure.
- Idle 100 cycles after the last result -> output_valid stays 0 and input_ready stays 1.
- Assert reset during OUTPUT, then send new_matrix=0 with x=(1,2,3) -> outputs 0,0,0 because W was cleared. Assert reset mid-LOAD_W, then send a full load -> correct results.
- Overflow: W all -8192, x all -8192 -> each y = 3·2^26 wrapped to 28 bits = -67108864.
